ps2_kbd_receiver: RTL and testbench

//   Receives PS/2 keyboard device-to-host frames and checks start, parity and stop bits.

---
 rtl/ps2_kbd_receiver.sv | 124 ++++++++++++
 tb/tb_ps2_kbd_receiver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: synchronises the device clock, assembles 11-bit
// device-to-host frames, validates start/parity/stop and queues good scan
// codes in a small FIFO whose head is presented to the consumer.
module ps2_kbd_receiver #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned SYNC_STAGES = 3
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_fall;

   logic [9:0]             r_buf;
   logic [3:0]             r_cnt;
   logic                   r_push;
   logic [7:0]             r_push_byte;
   logic                   w_frame_ok;

   logic                   r_nd;
   logic                   r_nd_d;
   logic                   w_pop;

   logic [7:0]             r_fifo [FIFO_DEPTH];
   logic [AW-1:0]          r_wptr;
   logic [AW-1:0]          r_rptr;
   logic [AW-1:0]          w_wptr_nxt;
   logic [AW-1:0]          w_rptr_nxt;
   logic                   w_full;
   logic                   w_wr;
   logic                   r_ready;
   logic                   r_overflow;

   // The oldest two synchroniser stages form the edge detector; reset to 1s
   // so a ps2_clk held low across reset release is not taken as an edge.
   assign w_fall = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];

   // Synchronise ps2_clk into the clk domain
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_sync <= '1;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], ps2_clk};
   end

   // Stop bit is the live ps2_data on the 11th edge; the rest come from r_buf
   assign w_frame_ok = ~r_buf[0] & ps2_data & (^r_buf[9:1]);

   // Collect frame bits on each ps2 falling edge and judge the frame on the 11th
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_buf       <= '0;
         r_cnt       <= '0;
         r_push      <= 1'b0;
         r_push_byte <= '0;
      end else begin
         r_push <= 1'b0;
         if (w_fall) begin
            if (r_cnt == 4'd10) begin
               r_cnt <= '0;
               if (w_frame_ok) begin
                  r_push      <= 1'b1;
                  r_push_byte <= r_buf[8:1];
               end
            end else begin
               r_buf[r_cnt] <= ps2_data;
               r_cnt        <= r_cnt + 4'd1;
            end
         end
      end
   end

   // Register nextdata_n twice so a held-low request yields a single pop
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_nd   <= 1'b1;
         r_nd_d <= 1'b1;
      end else begin
         r_nd   <= nextdata_n;
         r_nd_d <= r_nd;
      end
   end

   assign w_pop  = r_nd_d & ~r_nd & r_ready;
   assign w_full = ((r_wptr + AW'(1)) == r_rptr);
   assign w_wr   = r_push & ~w_full;

   // Next pointer values so ready reflects a simultaneous push and pop
   always_comb begin
      w_wptr_nxt = r_wptr;
      w_rptr_nxt = r_rptr;
      if (w_wr)  w_wptr_nxt = r_wptr + AW'(1);
      if (w_pop) w_rptr_nxt = r_rptr + AW'(1);
   end

   // FIFO storage, pointers, ready and sticky overflow
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_ready    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) r_fifo[r_wptr] <= r_push_byte;
         if (r_push && w_full) r_overflow <= 1'b1;
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_ready <= (w_wptr_nxt != w_rptr_nxt);
      end
   end

   assign data     = r_fifo[r_rptr];
   assign ready    = r_ready;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Bench for ps2_kbd_receiver: drives PS/2 frames and consumer pops, and
// compares outputs against a queue-based model of the scan-code FIFO.
module tb_ps2_kbd_receiver;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       clrn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] mq[$];
   logic       movf = 1'b0;

   ps2_kbd_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .nextdata_n(nextdata_n),
      .data      (data),
      .ready     (ready),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // err: 0 good, 1 bad parity, 2 bad stop, 3 bad start; nedges < 11 sends a partial frame
   task automatic send_frame(input logic [7:0] b, input int err, input int nedges);
      logic [10:0] fr;
      fr = {(err != 2), (~^b) ^ (err == 1), b, (err == 3)};
      for (int i = 0; i < nedges; i++) begin
         ps2_data = fr[i];
         repeat (4) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (5) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (8) @(negedge clk);
      if (nedges == 11 && err == 0) begin
         if (mq.size() >= DEPTH - 1) movf = 1'b1;
         else mq.push_back(b);
      end
   endtask

   task automatic do_pop(input int hold);
      logic [7:0] tmp;
      nextdata_n = 1'b0;
      repeat (hold) @(negedge clk);
      nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      if (mq.size() > 0) tmp = mq.pop_front();
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
      mq.delete();
      movf = 1'b0;
   endtask

   task automatic test_reset();
      clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
      n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", data); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      clrn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      send_frame(8'h1C, 0, 11);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%b exp=1", ready); end
      n_cmp++; if (data !== 8'h1C) begin n_bad++; $display("FAIL single_data got=%h exp=1c", data); end
      nextdata_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL pop_lat1 got=%b exp=1", ready); end
      @(negedge clk);
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL pop_lat2 got=%b exp=0", ready); end
      nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      void'(mq.pop_front());
   endtask

   task automatic test_sequence();
      logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
      for (int i = 0; i < 3; i++) begin
         send_frame(seq[i], 0, 11);
         n_cmp++; if (ready !== 1'b1 || data !== seq[i]) begin n_bad++;
            $display("FAIL seq_data[%0d] got=%b/%h exp=1/%h", i, ready, data, seq[i]); end
         n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL seq_ovf got=%b exp=0", overflow); end
         do_pop(2);
      end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL seq_empty got=%b exp=0", ready); end
   endtask

   task automatic test_burst();
      logic [7:0] seq [5] = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
      for (int i = 0; i < 5; i++) send_frame(seq[i], 0, 11);
      n_cmp++; if (ready !== 1'b1 || data !== 8'h1B) begin n_bad++;
         $display("FAIL burst_head got=%b/%h exp=1/1b", ready, data); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (ready !== 1'b1 || data !== seq[i]) begin n_bad++;
            $display("FAIL burst_pop[%0d] got=%b/%h exp=1/%h", i, ready, data, seq[i]); end
         do_pop(1);
      end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL burst_empty got=%b exp=0", ready); end
   endtask

   task automatic test_bad_frames();
      for (int e = 1; e <= 3; e++) begin
         send_frame(8'h1C, e, 11);
         n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL bad_frame[%0d] ready got=%b exp=0", e, ready); end
      end
      send_frame(8'hA5, 0, 11);
      n_cmp++; if (ready !== 1'b1 || data !== 8'hA5) begin n_bad++;
         $display("FAIL after_bad got=%b/%h exp=1/a5", ready, data); end
      do_pop(1);
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL after_bad_empty got=%b exp=0", ready); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) send_frame(8'($urandom), 0, 11);
      n_cmp++; if (overflow !== movf) begin n_bad++; $display("FAIL ovf_set got=%b exp=%b", overflow, movf); end
      for (int i = 0; i < 7; i++) begin
         exp = mq[0];
         n_cmp++; if (ready !== 1'b1 || data !== exp) begin n_bad++;
            $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, ready, data, exp); end
         do_pop(1);
      end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got=%b exp=0", ready); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      do_reset();
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h1C, 0, 5);
      do_reset();
      send_frame(8'h1B, 0, 11);
      n_cmp++; if (ready !== 1'b1 || data !== 8'h1B) begin n_bad++;
         $display("FAIL midreset_data got=%b/%h exp=1/1b", ready, data); end
      send_frame(8'h5A, 0, 11);
      do_pop(10);
      n_cmp++; if (ready !== 1'b1 || data !== 8'h5A) begin n_bad++;
         $display("FAIL hold_low_one_pop got=%b/%h exp=1/5a", ready, data); end
      do_pop(1);
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midreset_empty got=%b exp=0", ready); end
   endtask

   task automatic test_random();
      int op;
      for (int it = 0; it < 50; it++) begin
         op = $urandom_range(0, 9);
         if (op < 6) send_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 11);
         else do_pop($urandom_range(1, 6));
         n_cmp++; if (ready !== (mq.size() != 0)) begin n_bad++;
            $display("FAIL rnd_ready[%0d] got=%b exp=%b", it, ready, mq.size() != 0); end
         if (mq.size() != 0) begin
            n_cmp++; if (data !== mq[0]) begin n_bad++;
               $display("FAIL rnd_data[%0d] got=%h exp=%h", it, data, mq[0]); end
         end
         n_cmp++; if (overflow !== movf) begin n_bad++;
            $display("FAIL rnd_ovf[%0d] got=%b exp=%b", it, overflow, movf); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_burst();
      test_bad_frames();
      test_overflow();
      test_reset_midframe();
      do_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
